seq_stream_arbiter: RTL

- Shares one serial sequence-detector FSM (single `seq` bit input plus a clear) among NREQ requesters.
- Each requester submits a frame of serial bits with a declared length.
- The arbiter grants round-robin, clears the detector before each frame and steers the granted requester's bit stream onto the detector input.
- It reports completion, or aborts on a stalled stream.

---
 rtl/seq_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 37 +++
 rtl/seq_stream_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seq_arb_pkg.sv
// Shared definitions for the sequence-detector stream arbiter.
//   state_t          : arbiter FSM state encoding
//   DEFAULT_TIMEOUT  : default stall limit (cycles without bit_valid) in STREAM
package seq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CLEAR  = 2'b01,
        STREAM = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority search.
// Ports:
//   req      in  NREQ   request vector
//   ptr      in  IDX_W  index of the last served requester
//   win      out NREQ   one-hot winner (zero when no request)
//   win_idx  out IDX_W  index of the winner
//   any      out 1      at least one request present
module rr_picker #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [IDX_W-1:0] j;

    // Search upward starting one past the last served index, wrapping at NREQ.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            j = IDX_W'((32'(ptr) + i) % NREQ);
            if (!any && req[j]) begin
                any      = 1'b1;
                win_idx  = j;
                win[j]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_stream_arbiter.sv
// Round-robin arbiter sharing one serial sequence detector among NREQ
// requesters. Each granted frame starts with a one-cycle detector clear,
// then streams the granted requester's bits until the latched length is
// consumed (done) or the stream stalls for TIMEOUT cycles (abort).
// Ports:
//   clk        in  1           clock, rising edge
//   rst        in  1           asynchronous active-low reset
//   req        in  NREQ        frame requests, sampled in IDLE
//   len        in  NREQ*LEN_W  per-requester frame length, latched at grant
//   bit_valid  in  NREQ        per-requester serial bit valid
//   bit_in     in  NREQ        per-requester serial bit
//   ready      out NREQ        bit accepted when ready[i] & bit_valid[i]
//   gnt        out NREQ        registered one-hot grant
//   det_clear  out 1           registered detector clear pulse
//   seq_out    out 1           bit steered to the detector
//   seq_valid  out 1           seq_out valid this cycle
//   done       out 1           frame completed pulse
//   abort      out 1           frame timed-out pulse
//   busy       out 1           arbiter not idle
module seq_stream_arbiter
    import seq_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    input  logic [NREQ-1:0]       bit_valid,
    input  logic [NREQ-1:0]       bit_in,
    output logic [NREQ-1:0]       ready,
    output logic [NREQ-1:0]       gnt,
    output logic                  det_clear,
    output logic                  seq_out,
    output logic                  seq_valid,
    output logic                  done,
    output logic                  abort,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned TM_W  = $clog2(TIMEOUT);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [LEN_W-1:0]   cnt;
    logic [TM_W-1:0]    timer;

    logic [NREQ-1:0]    pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               accept;
    logic               timeout_hit;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    assign accept      = (state == STREAM) && bit_valid[gidx];
    // A valid bit on the threshold cycle counts as an accept, so accept wins.
    assign timeout_hit = (state == STREAM) && !bit_valid[gidx] &&
                         (timer == TM_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = CLEAR;
            CLEAR:   state_next = (cnt != '0) ? STREAM : DONE;
            STREAM: begin
                if (accept && (cnt == LEN_W'(1))) state_next = DONE;
                else if (timeout_hit)             state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready     = '0;
        seq_valid = 1'b0;
        seq_out   = 1'b0;
        if (state == STREAM) begin
            ready     = gnt;
            seq_valid = bit_valid[gidx];
            seq_out   = bit_in[gidx];
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gidx      <= '0;
            ptr       <= IDX_W'(NREQ - 1);
            cnt       <= '0;
            timer     <= '0;
            det_clear <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_next;
            det_clear <= (state_next == CLEAR);
            done      <= (state_next == DONE);
            abort     <= timeout_hit;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= pick_win;
                        gidx  <= pick_idx;
                        cnt   <= len[32'(pick_idx)*LEN_W +: LEN_W];
                        timer <= '0;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        cnt   <= cnt - 1'b1;
                        timer <= '0;
                    end else if (timeout_hit) begin
                        gnt   <= '0;
                        ptr   <= gidx;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    gnt <= '0;
                    ptr <= gidx;
                end
                default: ;
            endcase
        end
    end

endmodule
